// File: rtl/btn_cond.sv
// btn_cond: five independent push-button conditioners.
// Each channel synchronises the raw button, debounces it into a clean
// level (BTNQ) and emits a one-cycle pulse (BTNP) on every accepted press.
// With REP_EN high, a held button also produces repeat pulses: the first
// one REP_DELAY cycles after the press, then one every REP_PERIOD cycles.
//
// Repeat phase per channel:
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   PH_DELAY  | waiting REP_DELAY cycles after the press for the first repeat
//   PH_PERIOD | first repeat issued; pulsing every REP_PERIOD cycles
module btn_cond #(
  parameter logic [31:0] DEB_CNT    = 32'd1_000_000,
  parameter logic [31:0] REP_DELAY  = 32'd50_000_000,
  parameter logic [31:0] REP_PERIOD = 32'd10_000_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [4:0] BTN,
  input  logic       REP_EN,
  output logic [4:0] BTNQ,
  output logic [4:0] BTNP
);

  typedef enum logic {
    PH_DELAY  = 1'b0,
    PH_PERIOD = 1'b1
  } phase_e;

  // Terminal counts: each counter runs 0 .. N-1, so N cycles per interval.
  localparam logic [31:0] DEB_TC = DEB_CNT - 32'd1;
  localparam logic [31:0] DLY_TC = REP_DELAY - 32'd1;
  localparam logic [31:0] PER_TC = REP_PERIOD - 32'd1;

  logic [4:0] s1_q;
  logic [4:0] s2_q;

  // Two-flop synchroniser for the asynchronous button inputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= BTN;
      s2_q <= s1_q;
    end
  end

  for (genvar i = 0; i < 5; i++) begin : g_ch
    logic [31:0] dc_q, dc_d;
    logic        lvl_q, lvl_d;
    logic [31:0] rc_q, rc_d;
    phase_e      ph_q, ph_d;
    logic        pls_q, pls_d;
    logic        rep_fire;
    logic        rep_run;

    // Debounce: count consecutive cycles where the synchronised input
    // disagrees with the accepted level; any agreement restarts the count.
    always_comb begin
      dc_d  = dc_q;
      lvl_d = lvl_q;
      if (s2_q[i] == lvl_q) begin
        dc_d = '0;
      end else if (dc_q == DEB_TC) begin
        lvl_d = s2_q[i];
        dc_d  = '0;
      end else begin
        dc_d = dc_q + 32'd1;
      end
    end

    // Repeat counting only runs while the level is (and stays) high and
    // repeat is enabled. Checking lvl_d as well keeps the release edge
    // from firing a repeat pulse; checking lvl_q means the press edge
    // always starts from rc=0 in PH_DELAY.
    assign rep_run = lvl_q & lvl_d & REP_EN;

    // Repeat phase next-state and fire decode.
    always_comb begin
      rc_d     = rc_q;
      ph_d     = ph_q;
      rep_fire = 1'b0;
      if (!rep_run) begin
        rc_d = '0;
        ph_d = PH_DELAY;
      end else begin
        case (ph_q)
          PH_DELAY: begin
            if (rc_q == DLY_TC) begin
              rep_fire = 1'b1;
              rc_d     = '0;
              ph_d     = PH_PERIOD;
            end else begin
              rc_d = rc_q + 32'd1;
            end
          end
          PH_PERIOD: begin
            if (rc_q == PER_TC) begin
              rep_fire = 1'b1;
              rc_d     = '0;
            end else begin
              rc_d = rc_q + 32'd1;
            end
          end
          default: begin
            rc_d = '0;
            ph_d = PH_DELAY;
          end
        endcase
      end
    end

    // Output pulse: accepted rising level, or a repeat tick.
    assign pls_d = (lvl_d & ~lvl_q) | rep_fire;

    // Channel state registers.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        dc_q  <= '0;
        lvl_q <= 1'b0;
        rc_q  <= '0;
        ph_q  <= PH_DELAY;
        pls_q <= 1'b0;
      end else begin
        dc_q  <= dc_d;
        lvl_q <= lvl_d;
        rc_q  <= rc_d;
        ph_q  <= ph_d;
        pls_q <= pls_d;
      end
    end

    assign BTNQ[i] = lvl_q;
    assign BTNP[i] = pls_q;
  end

endmodule

// File: tb/tb_btn_cond.sv
// tb_btn_cond: scoreboard bench for btn_cond with DEB_CNT=4,
// REP_DELAY=20, REP_PERIOD=5. Each stimulus step pushes the expected
// {BTNQ,BTNP} for the edge it feeds; a monitor pops it 1 ns after that edge.
module tb_btn_cond;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       REP_EN = 1'b0;
  logic [4:0] BTN = 5'b0;
  logic [4:0] BTNQ;
  logic [4:0] BTNP;

  int    n_cmp = 0;
  int    n_err = 0;
  string cur_tag = "idle";
  logic [9:0] sb_q[$];

  btn_cond #(
    .DEB_CNT   (32'd4),
    .REP_DELAY (32'd20),
    .REP_PERIOD(32'd5)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .BTN   (BTN),
    .REP_EN(REP_EN),
    .BTNQ  (BTNQ),
    .BTNP  (BTNP)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got Q=%b P=%b expected Q=%b P=%b", tag,
               got[9:5], got[4:0], exp[9:5], exp[4:0]);
    end
  endtask

  // Drive inputs sampled at the next rising edge and queue what that edge must produce.
  task automatic drive(input logic [4:0] btn, input logic rep,
                       input logic [4:0] eq, input logic [4:0] ep);
    @(negedge CLK);
    BTN    = btn;
    REP_EN = rep;
    sb_q.push_back({eq, ep});
  endtask

  task automatic settle();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (sb_q.size() > 0) chk(cur_tag, {BTNQ, BTNP}, sb_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset asserted between edges must clear outputs immediately.
    #2 RST = 1'b1;
    #1 chk("rst_async", {BTNQ, BTNP}, 10'b0);
    @(posedge CLK);
    #1 chk("rst_hold", {BTNQ, BTNP}, 10'b0);
    #1 RST = 1'b0;

    // 1: clean press/release on C, no repeat.
    cur_tag = "t1_press_release";
    for (int e = 0; e < 40; e++)
      drive((e < 30) ? 5'b00100 : 5'b0, 1'b0,
            (e >= 5 && e < 35) ? 5'b00100 : 5'b0,
            (e == 5) ? 5'b00100 : 5'b0);
    settle();

    // 2: bounce on D, two cycles per level, never accepted.
    cur_tag = "t2_bounce";
    for (int e = 0; e < 16; e++)
      drive((e < 2 || (e >= 4 && e < 6)) ? 5'b00001 : 5'b0, 1'b1, 5'b0, 5'b0);
    settle();

    // 3: auto-repeat on U held 60 cycles; the would-be repeat at 65 coincides with release.
    cur_tag = "t3_repeat";
    for (int e = 0; e < 72; e++)
      drive((e < 60) ? 5'b10000 : 5'b0, 1'b1,
            (e >= 5 && e < 65) ? 5'b10000 : 5'b0,
            (e == 5 || (e >= 25 && e <= 60 && (e - 25) % 5 == 0)) ? 5'b10000 : 5'b0);
    settle();

    // 4: L and R pressed together.
    cur_tag = "t4_simul";
    for (int e = 0; e < 25; e++)
      drive((e < 15) ? 5'b01010 : 5'b0, 1'b0,
            (e >= 5 && e < 20) ? 5'b01010 : 5'b0,
            (e == 5) ? 5'b01010 : 5'b0);
    settle();

    // 5: REP_EN low right after edge 27, high again right after edge 33.
    cur_tag = "t5_rep_drop";
    for (int e = 0; e < 82; e++)
      drive((e < 70) ? 5'b10000 : 5'b0, !(e >= 28 && e <= 33),
            (e >= 5 && e < 75) ? 5'b10000 : 5'b0,
            (e == 5 || e == 25 || (e >= 53 && e <= 73 && (e - 53) % 5 == 0)) ? 5'b10000 : 5'b0);
    settle();

    // 6a: reset in the middle of a debounce count; acceptance restarts from scratch.
    cur_tag = "t6_midcount";
    for (int e = 0; e < 4; e++)
      drive(5'b00100, 1'b1, 5'b0, 5'b0);
    @(posedge CLK);
    #3 RST = 1'b1;
    #1 chk("t6_rst_count", {BTNQ, BTNP}, 10'b0);
    @(posedge CLK);
    #2 RST = 1'b0;

    // First edge after release is e=0 here.
    cur_tag = "t6_after_rst";
    for (int e = 0; e <= 30; e++)
      drive(5'b00100, 1'b1,
            (e >= 5) ? 5'b00100 : 5'b0,
            (e == 5 || e == 25 || e == 30) ? 5'b00100 : 5'b0);

    // 6b: reset right after a repeat pulse; outputs drop without a clock edge.
    @(posedge CLK);
    #3 RST = 1'b1;
    #1 chk("t6_rst_rep", {BTNQ, BTNP}, 10'b0);
    @(posedge CLK);
    #1 chk("t6_rst_rep_hold", {BTNQ, BTNP}, 10'b0);
    #1 RST = 1'b0;

    cur_tag = "t6_rerelease";
    for (int e = 0; e < 22; e++)
      drive((e < 12) ? 5'b00100 : 5'b0, 1'b1,
            (e >= 5 && e < 17) ? 5'b00100 : 5'b0,
            (e == 5) ? 5'b00100 : 5'b0);
    settle();
    settle();

    if (sb_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
